alu_cmd_sequencer: RTL and testbench

- Byte-stream front-end that drives the team's combinational 8-bit ALU.
- Accepts commands as bytes over valid/ready: opcode, optional A, then B.
- Drives the ALU operand and select lines from registers and captures result and carry.
- Returns the result byte, plus an optional flags byte, over a valid/ready output stream.
- Holds an accumulator so operations can be chained without re-sending A.

---
 rtl/alu_cmd_sequencer_pkg.sv | 36 +++
 rtl/alu_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - opcode fields, FSM state codes and flag layout shared by the ALU command sequencer
package alu_cmd_sequencer_pkg;

  // Opcode byte field positions
  localparam int SEL_LSB      = 0;
  localparam int ACC_SRC_BIT  = 3;
  localparam int FLAGS_EN_BIT = 4;
  localparam int RSVD_LSB     = 5;
  localparam int RSVD_MSB     = 7;

  // Flags byte bit positions
  localparam int FLAG_CARRY_BIT = 0;
  localparam int FLAG_ZERO_BIT  = 1;

  // Response byte returned for an opcode with reserved bits set
  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_A    = 3'd1;
  localparam logic [2:0] ST_GET_B    = 3'd2;
  localparam logic [2:0] ST_EXEC     = 3'd3;
  localparam logic [2:0] ST_SEND_RES = 3'd4;
  localparam logic [2:0] ST_SEND_FLG = 3'd5;
  localparam logic [2:0] ST_ERR      = 3'd6;

  // Build the flags byte from the stored zero and carry indications
  function automatic logic [7:0] make_flags(input logic zero, input logic carry);
    logic [7:0] f;
    f = 8'h00;
    f[FLAG_ZERO_BIT]  = zero;
    f[FLAG_CARRY_BIT] = carry;
    return f;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - byte-stream command front-end driving an external combinational ALU
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SEL_W    = 3,
  parameter logic [DATA_W-1:0] ERR_BYTE = ERR_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              cmd_err,
  output logic              busy
);

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              flags_en_q, flags_en_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              cmd_err_q, cmd_err_d;

  // The response stream is driven straight from state so data and valid stay frozen under backpressure
  always_comb begin
    in_ready  = (state_q == ST_IDLE) || (state_q == ST_GET_A) || (state_q == ST_GET_B);
    out_valid = (state_q == ST_SEND_RES) || (state_q == ST_SEND_FLG) || (state_q == ST_ERR);
    case (state_q)
      ST_SEND_RES: out_data = res_q;
      ST_SEND_FLG: out_data = DATA_W'(make_flags(res_q == '0, carry_q));
      ST_ERR:      out_data = ERR_BYTE;
      default:     out_data = '0;
    endcase
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign cmd_err = cmd_err_q;
  assign busy    = (state_q != ST_IDLE);

  // Next-state and datapath update; in_ready is 1 in every input-collecting state so in_valid alone marks a transfer there
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    flags_en_d = flags_en_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    res_d      = res_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    cmd_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_data[RSVD_MSB:RSVD_LSB] != '0) begin
            // Malformed opcode leaves every operand and the accumulator untouched
            state_d   = ST_ERR;
            cmd_err_d = 1'b1;
          end else begin
            sel_d      = in_data[SEL_LSB +: SEL_W];
            flags_en_d = in_data[FLAGS_EN_BIT];
            if (in_data[ACC_SRC_BIT]) begin
              alu_a_d = acc_q;
              state_d = ST_GET_B;
            end else begin
              state_d = ST_GET_A;
            end
          end
        end
      end
      ST_GET_A: begin
        if (in_valid) begin
          alu_a_d = in_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (in_valid) begin
          alu_b_d   = in_data;
          alu_sel_d = sel_q;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU inputs have been stable for a full cycle here
        res_d   = alu_result;
        carry_d = alu_carry;
        acc_d   = alu_result;
        state_d = ST_SEND_RES;
      end
      ST_SEND_RES: begin
        if (out_ready) state_d = flags_en_q ? ST_SEND_FLG : ST_IDLE;
      end
      ST_SEND_FLG: begin
        if (out_ready) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register update; reset discards any partial command or pending response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      flags_en_q <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      flags_en_q <= flags_en_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      acc_q      <= acc_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed vector bench for the ALU command sequencer with a behavioural ALU
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       cmd_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cur    = -1;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_a;
    logic [7:0] exp_res;
    logic [7:0] exp_flg;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DATA_W  (8),
    .SEL_W   (3),
    .ERR_BYTE(8'hEE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .alu_carry (alu_carry),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  // Behavioural ALU: 0 add, 1 sub (carry = no borrow), 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 pass B
  always_comb begin
    logic [8:0] t;
    t = 9'h000;
    case (alu_sel)
      3'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: t = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      3'd2: t = {1'b0, alu_a & alu_b};
      3'd3: t = {1'b0, alu_a | alu_b};
      3'd4: t = {1'b0, alu_a ^ alu_b};
      3'd5: t = {alu_a[7], alu_a[6:0], 1'b0};
      3'd6: t = {alu_a[0], 1'b0, alu_a[7:1]};
      default: t = {1'b0, alu_b};
    endcase
    alu_result = t[7:0];
    alu_carry  = t[8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, cur, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout (vec %0d): in_ready stayed 0 for byte 0x%0h", cur, b);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_cmd(input vec_t v);
    send_byte(v.op);
    if (v.op[7:5] != 3'b000) begin
      chk("cmd_err_first", cmd_err, 1);
      chk("err_valid", out_valid, 1);
      chk("err_data", out_data, 8'hEE);
      step();
      chk("cmd_err_pulse", cmd_err, 0);
      chk("err_hold", out_valid, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end else begin
      if (!v.op[3]) send_byte(v.a);
      send_byte(v.b);
      chk("exec_valid", out_valid, 0);
      chk("exec_busy", busy, 1);
      chk("alu_a", alu_a, v.exp_a);
      chk("alu_b", alu_b, v.b);
      chk("alu_sel", alu_sel, v.op[2:0]);
      step();
      chk("res_valid", out_valid, 1);
      chk("res_data", out_data, v.exp_res);
      out_ready = 1'b1;
      step();
      if (v.op[4]) begin
        chk("flg_valid", out_valid, 1);
        chk("flg_data", out_data, v.exp_flg);
        step();
      end
      out_ready = 1'b0;
    end
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{8'h10, 8'hF0, 8'h20, 8'hF0, 8'h10, 8'h01};
    vecs[1]  = '{8'h19, 8'h00, 8'h10, 8'h10, 8'h00, 8'h03};
    vecs[2]  = '{8'h05, 8'h81, 8'h00, 8'h81, 8'h02, 8'h00};
    vecs[3]  = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    vecs[5]  = '{8'h00, 8'h03, 8'h04, 8'h03, 8'h07, 8'h00};
    vecs[6]  = '{8'h1A, 8'h00, 8'h05, 8'h07, 8'h05, 8'h00};
    vecs[7]  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    vecs[8]  = '{8'h0C, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[9]  = '{8'h1E, 8'h00, 8'h00, 8'hFF, 8'h7F, 8'h01};
    vecs[10] = '{8'h17, 8'h12, 8'h00, 8'h12, 8'h00, 8'h02};
    vecs[11] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[12] = '{8'h09, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00};

    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      cur = i;
      run_cmd(vecs[i]);
    end

    // Backpressure: response held for 5 cycles, then result and flags on consecutive cycles
    cur = 100;
    send_byte(8'h10);
    send_byte(8'hF0);
    send_byte(8'h20);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'h10);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_flg_valid", out_valid, 1);
    chk("bp_flg_data", out_data, 8'h01);
    step();
    chk("bp_done", out_valid, 0);
    out_ready = 1'b0;

    // Reset mid-command: the partial 0x00, 0x55 is dropped
    cur = 101;
    send_byte(8'h00);
    send_byte(8'h55);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    v = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h03, 8'h00};
    run_cmd(v);

    // Reset with a response pending: response dropped and accumulator cleared
    cur = 102;
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    step();
    chk("pend_valid", out_valid, 1);
    chk("pend_data", out_data, 8'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("pend_rst_valid", out_valid, 0);
    v = '{8'h08, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    run_cmd(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
